// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Includes the state encoding, memory command codes and the HALT opcode.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_IF_REQ    = 3'd1,
        ST_IF_WAIT   = 3'd2,
        ST_PC_UPD    = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_EXEC_WAIT = 3'd5,
        ST_EXEC_DONE = 3'd6,
        ST_HALT      = 3'd7
    } fetch_state_t;

    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam logic [1:0] MEM_READ    = 2'b01;
    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam logic [3:0] TIMEOUT_MAX = 4'd15;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:13] == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_PC,
// increments by one on inc and wraps modulo 2^PC_W.
module pc_reg #(
    parameter int PC_W     = 9,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= PC_W'(RESET_PC);
        end else if (inc) begin
            count_reg <= count_reg + PC_W'(1);
        end
    end

    assign pc = count_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/issue sequencer: reads 16-bit instructions, holds them in ir and
// starts the datapath controller. Define FETCH_TIMEOUT_EN for the fetch timeout.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W     = 9,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] mem_addr,
    output logic [1:0]      mem_cmd,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ready,
    output logic [15:0]     ir,
    output logic            s,
    input  logic            w,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [15:0]  ir_reg;
    logic         ir_load;
    logic         pc_inc;
    logic         timeout_hit;
    logic [PC_W-1:0] pc_value;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_inc),
        .pc    (pc_value)
    );

    assign pc_inc = (state_reg == ST_PC_UPD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_reg <= 16'h0000;
        end else if (ir_load) begin
            ir_reg <= mem_rdata;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt_reg;
    logic       fault_reg;

    // Counter holds the number of completed IF_WAIT cycles; the 15th miss ends the fetch.
    assign timeout_hit = (wait_cnt_reg == (TIMEOUT_MAX - 4'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= 4'd0;
            fault_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_IF_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end else begin
                wait_cnt_reg <= 4'd0;
            end
            if ((state_reg == ST_IF_WAIT) && !mem_ready && timeout_hit) begin
                fault_reg <= 1'b1;
            end
        end
    end

    assign fault = fault_reg;
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ir_load    = 1'b0;
        case (state_reg)
            ST_RST: begin
                if (run) begin
                    state_next = ST_IF_REQ;
                end
            end
            ST_IF_REQ: begin
                state_next = ST_IF_WAIT;
            end
            ST_IF_WAIT: begin
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    state_next = ST_PC_UPD;
                end else if (timeout_hit) begin
                    state_next = ST_HALT;
                end
            end
            ST_PC_UPD: begin
                state_next = is_halt(ir_reg) ? ST_HALT : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_next = ST_EXEC_WAIT;
            end
            ST_EXEC_WAIT: begin
                // w low proves the datapath left idle and took the instruction.
                if (!w) begin
                    state_next = ST_EXEC_DONE;
                end
            end
            ST_EXEC_DONE: begin
                if (w) begin
                    state_next = run ? ST_IF_REQ : ST_RST;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RST;
            end
        endcase
    end

    // Outputs decode from registered state/pc/ir only, so no input-to-output path.
    assign mem_cmd  = ((state_reg == ST_IF_REQ) || (state_reg == ST_IF_WAIT)) ? MEM_READ : MEM_NONE;
    assign mem_addr = pc_value;
    assign pc       = pc_value;
    assign ir       = ir_reg;
    assign s        = (state_reg == ST_ISSUE);
    assign halted   = (state_reg == ST_HALT);

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Top-level sequencer that fetches 16-bit instructions from instruction memory, holds them in the instruction register, and issues each one to the datapath controller via its `s`/`w` start/waiting handshake. Sits between the program memory and the datapath controller. Owns the program counter, memory request handshake and halt detection, so the datapath controller only ever sees a stable instruction plus a start pulse.

## Interface
- `PC_W`, 9, program counter / memory address width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  fetch enable; low stalls before the next fetch
- `mem_addr`  out  PC_W  instruction address, equals PC during fetch
- `mem_cmd`  out  2  memory command: NONE=2'b00, READ=2'b01
- `mem_rdata`  in  16  read data, valid when `mem_ready`=1
- `mem_ready`  in  1  read complete; arbitrary latency ≥1 cycle
- `ir`  out  16  instruction register, drives opcode/op/fields to the datapath
- `s`  out  1  start pulse to the datapath controller
- `w`  in  1  datapath controller waiting (idle) flag
- `pc`  out  PC_W  current program counter
- `halted`  out  1  high in HALT
- `fault`  out  1  fetch timeout flag (see Configuration)

## Operation
- States: RST, IF_REQ, IF_WAIT, PC_UPD, ISSUE, EXEC_WAIT, EXEC_DONE, HALT.
- RST → IF_REQ when `run`=1, otherwise hold in RST.
- IF_REQ: `mem_cmd`=READ, `mem_addr`=pc; next state IF_WAIT.
- IF_WAIT: `mem_cmd` stays READ. On `mem_ready`=1, `ir`←`mem_rdata` and go to PC_UPD.
- PC_UPD: pc←pc+1, modulo 2^PC_W (wraps to 0). If `ir[15:13]`=3'b111 (HALT opcode) go to HALT, otherwise go to ISSUE.
- ISSUE: `s`=1 for exactly this one cycle; next state EXEC_WAIT.
- EXEC_WAIT: wait for `w`=0, which confirms the datapath accepted the instruction, then go to EXEC_DONE.
- EXEC_DONE: wait for `w`=1. Then go to IF_REQ if `run`=1, or RST if `run`=0. PC is not reset on the RST return.
- HALT: absorbing state. `halted`=1, `mem_cmd`=NONE, `s`=0. Only reset exits it.
- `ir` changes only on a captured fetch. It is stable from PC_UPD until the next IF_WAIT capture.
- `mem_ready` outside IF_WAIT is ignored.
- `run` dropping mid-instruction does not abort the instruction; it only takes effect at the next fetch boundary.

## Timing
- Reset values: state=RST, pc=RESET_PC, `ir`=16'h0000, `mem_cmd`=NONE, `mem_addr`=RESET_PC, `s`=0, `halted`=0, `fault`=0.
- Reset asserted at any point aborts immediately and returns all outputs to their reset values; an in-flight read is dropped.
- All outputs are registered or decoded from state/pc/`ir` only. No combinational path from inputs to outputs.
- Minimum fetch-to-issue latency: IF_REQ(1) + IF_WAIT(1, with `mem_ready` in that cycle) + PC_UPD(1) → `s` high in the 4th cycle after leaving RST.
- `mem_addr` holds constant throughout IF_REQ/IF_WAIT.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A 4-bit counter runs in IF_WAIT.
  - If `mem_ready` has not arrived after 15 cycles in IF_WAIT, set `fault`=1 and go to HALT.
  - `fault` is sticky until reset.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter; IF_WAIT waits forever.
  - `fault` is tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - state enum
  - `mem_cmd` encodings (`MEM_NONE`, `MEM_READ`)
  - `HALT_OPCODE`=3'b111
  - `TIMEOUT_MAX`=15
- One sub-module `pc_reg`: PC_W-bit register with async active-low reset to RESET_PC and increment enable; wraps modulo 2^PC_W.

## Test plan
- Reset release, `run`=1, memory returns 16'hD105 with one-cycle ready → `mem_addr`=0, `ir`=16'hD105, `s` pulses once in cycle 4, pc=1.
- Three-instruction program with `w` toggling low for 3 cycles after each `s` → exactly three `s` pulses, fetch addresses 0, 1, 2, no refetch.
- Memory at address 3 = 16'hE000 (HALT) → `halted`=1 after PC_UPD, pc=4, no `s` pulse, `mem_cmd`=NONE thereafter.
- pc preset path: RESET_PC=511, PC_W=9 → after first fetch pc wraps to 0.
- Reset asserted while in IF_WAIT with `mem_ready` pending → `mem_cmd`=NONE and pc=RESET_PC asynchronously; late `mem_ready` ignored.
- With `FETCH_TIMEOUT_EN`, `mem_ready` held low → `fault`=1 and `halted`=1 after 15 IF_WAIT cycles; without the macro, state remains IF_WAIT after 100 cycles.
